// File: rtl/mux_arb.sv
// Registered N:1 word mux with valid/ready handshake; fixed-select or round-robin grant.
// Output stage carries the word, its complement and the winning channel index.
module mux_arb #(
   parameter int WLOG   = 3,
   parameter int WWIDTH = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [(1<<WLOG)-1:0][WWIDTH-1:0]      a,
   input  logic [(1<<WLOG)-1:0]                  a_valid,
   output logic [(1<<WLOG)-1:0]                  a_ready,
   input  logic                                  mode,
   input  logic [WLOG-1:0]                       sel,
   output logic [WWIDTH-1:0]                     out,
   output logic [WWIDTH-1:0]                     out_neg,
   output logic [WLOG-1:0]                       out_ch,
   output logic                                  out_valid,
   input  logic                                  out_ready
);

   localparam int N = 1 << WLOG;

   logic            load_en;
   logic            grant_vld;
   logic [WLOG-1:0] g;
   logic [WLOG-1:0] scan;
   logic [WLOG-1:0] ptr;

   assign load_en = !out_valid || out_ready;

   // rr scan starts at ptr and wraps through natural WLOG-bit overflow
   always_comb begin
      grant_vld = 1'b0;
      g         = '0;
      scan      = '0;
      if (!mode) begin
         g         = sel;
         grant_vld = a_valid[sel];
      end else begin
         for (int k = 0; k < N; k++) begin
            scan = ptr + WLOG'(k);
            if (!grant_vld && a_valid[scan]) begin
               grant_vld = 1'b1;
               g         = scan;
            end
         end
      end
   end

   always_comb begin
      a_ready = '0;
      if (grant_vld && load_en && !rst)
         a_ready[g] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         out_neg   <= '1;
         out_ch    <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
      end else if (load_en) begin
         if (grant_vld) begin
            out       <= a[g];
            out_neg   <= ~a[g];
            out_ch    <= g;
            out_valid <= 1'b1;
            if (mode)
               ptr <= g + WLOG'(1);
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_arb.sv
// Directed bench for mux_arb: reset, fixed select, rr fairness/sparse grants,
// backpressure, and mid-stream reset with a mode switch.
module tb_mux_arb;

   logic                 clk;
   logic                 rst;
   logic [7:0][7:0]      a;
   logic [7:0]           a_valid;
   logic [7:0]           a_ready;
   logic                 mode;
   logic [2:0]           sel;
   logic [7:0]           out;
   logic [7:0]           out_neg;
   logic [2:0]           out_ch;
   logic                 out_valid;
   logic                 out_ready;

   int n_cmp = 0;
   int n_bad = 0;

   mux_arb #(.WLOG(3), .WWIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .mode      (mode),
      .sel       (sel),
      .out       (out),
      .out_neg   (out_neg),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; mode = 1'b1; sel = 3'd0; a_valid = 8'hFF; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) a[i] = 8'(i + 16);
      for (int c = 0; c < 2; c++) begin
         #1;
         n_cmp++;
         if (a_ready !== 8'h00) begin
            n_bad++; $display("FAIL reset_a_ready[%0d]: got %b want 00000000", c, a_ready);
         end
         tick();
      end
      n_cmp++;
      if (out !== 8'h00) begin n_bad++; $display("FAIL reset_out: got %h want 00", out); end
      n_cmp++;
      if (out_neg !== 8'hFF) begin n_bad++; $display("FAIL reset_out_neg: got %h want ff", out_neg); end
      n_cmp++;
      if (out_ch !== 3'd0) begin n_bad++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      rst = 1'b0; a_valid = 8'h00;
   endtask

   task automatic test_fixed();
      mode = 1'b0; sel = 3'd5; a[5] = 8'd12; a_valid = 8'b0010_0000; out_ready = 1'b1;
      #1;
      n_cmp++;
      if (a_ready !== 8'b0010_0000) begin n_bad++; $display("FAIL fixed_a_ready: got %b want 00100000", a_ready); end
      tick();
      n_cmp++;
      if (out !== 8'd12) begin n_bad++; $display("FAIL fixed_out: got %0d want 12", out); end
      n_cmp++;
      if (out_neg !== 8'd243) begin n_bad++; $display("FAIL fixed_out_neg: got %0d want 243", out_neg); end
      n_cmp++;
      if (out_ch !== 3'd5) begin n_bad++; $display("FAIL fixed_out_ch: got %0d want 5", out_ch); end
      n_cmp++;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL fixed_out_valid: got %b want 1", out_valid); end
      // channel 2 idle while others are valid: nothing may be granted
      sel = 3'd2; a_valid = 8'b1111_1011;
      #1;
      n_cmp++;
      if (a_ready !== 8'h00) begin n_bad++; $display("FAIL fixed_nogrant_ready: got %b want 00000000", a_ready); end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fixed_nogrant_valid: got %b want 0", out_valid); end
      n_cmp++;
      if (out !== 8'd12 || out_ch !== 3'd5) begin
         n_bad++; $display("FAIL fixed_nogrant_hold: got out=%0d ch=%0d want out=12 ch=5", out, out_ch);
      end
      a[5] = 8'd21; a_valid = 8'h00;
   endtask

   task automatic test_rr_fair();
      logic [7:0] exp_rdy;
      int         exp_ch;
      mode = 1'b1; a_valid = 8'hFF; out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         exp_ch  = i % 8;
         exp_rdy = 8'(1 << exp_ch);
         #1;
         n_cmp++;
         if (a_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_fair_ready[%0d]: got %b want %b", i, a_ready, exp_rdy); end
         tick();
         n_cmp++;
         if (out_ch !== 3'(exp_ch)) begin n_bad++; $display("FAIL rr_fair_ch[%0d]: got %0d want %0d", i, out_ch, exp_ch); end
         n_cmp++;
         if (out !== 8'(exp_ch + 16) || out_neg !== ~8'(exp_ch + 16) || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_fair_data[%0d]: got out=%0d neg=%h v=%b want out=%0d", i, out, out_neg, out_valid, exp_ch + 16);
         end
      end
      a_valid = 8'h00;
   endtask

   task automatic test_rr_sparse();
      logic [7:0] exp_rdy;
      int         exp_ch;
      rst = 1'b1; a_valid = 8'h00;
      tick();
      rst = 1'b0; mode = 1'b1; a_valid = 8'b1000_0100; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_ch  = (i % 2 == 0) ? 2 : 7;
         exp_rdy = 8'(1 << exp_ch);
         #1;
         n_cmp++;
         if (a_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_sparse_ready[%0d]: got %b want %b", i, a_ready, exp_rdy); end
         tick();
         n_cmp++;
         if (out_ch !== 3'(exp_ch) || out !== 8'(exp_ch + 16)) begin
            n_bad++; $display("FAIL rr_sparse_out[%0d]: got ch=%0d out=%0d want ch=%0d", i, out_ch, out, exp_ch);
         end
      end
      a_valid = 8'h00;
   endtask

   task automatic test_backpressure();
      // ptr is 0 after the sparse run ended on channel 7
      mode = 1'b1; a_valid = 8'hFF; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++;
         if (a_ready !== 8'h00) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 00000000", c, a_ready); end
         tick();
         n_cmp++;
         if (out !== 8'd16 || out_neg !== 8'hEF || out_ch !== 3'd0 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_hold[%0d]: got out=%0d neg=%h ch=%0d v=%b want out=16 neg=ef ch=0 v=1",
                     c, out, out_neg, out_ch, out_valid);
         end
      end
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (a_ready !== 8'b0000_0010) begin n_bad++; $display("FAIL bp_release_ready: got %b want 00000010", a_ready); end
      tick();
      n_cmp++;
      if (out_ch !== 3'd1 || out !== 8'd17 || out_valid !== 1'b1) begin
         n_bad++; $display("FAIL bp_release_out: got ch=%0d out=%0d v=%b want ch=1 out=17 v=1", out_ch, out, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      // out_valid=1 and ptr=2 on entry; the reset must drop both
      out_ready = 1'b0; rst = 1'b1;
      #1;
      n_cmp++;
      if (a_ready !== 8'h00) begin n_bad++; $display("FAIL midrst_ready: got %b want 00000000", a_ready); end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || out !== 8'h00 || out_neg !== 8'hFF || out_ch !== 3'd0) begin
         n_bad++;
         $display("FAIL midrst_out: got v=%b out=%h neg=%h ch=%0d want v=0 out=00 neg=ff ch=0", out_valid, out, out_neg, out_ch);
      end
      rst = 1'b0; out_ready = 1'b1; mode = 1'b1; a_valid = 8'hFF;
      tick();
      n_cmp++;
      if (out_ch !== 3'd0) begin n_bad++; $display("FAIL midrst_ptr0: got ch=%0d want 0", out_ch); end
      tick();
      n_cmp++;
      if (out_ch !== 3'd1) begin n_bad++; $display("FAIL midrst_ptr1: got ch=%0d want 1", out_ch); end
      // fixed grant of 6 must not disturb ptr (=2)
      mode = 1'b0; sel = 3'd6;
      #1;
      n_cmp++;
      if (a_ready !== 8'b0100_0000) begin n_bad++; $display("FAIL switch_fixed_ready: got %b want 01000000", a_ready); end
      tick();
      n_cmp++;
      if (out_ch !== 3'd6 || out !== 8'd22) begin n_bad++; $display("FAIL switch_fixed_out: got ch=%0d out=%0d want ch=6 out=22", out_ch, out); end
      mode = 1'b1;
      #1;
      n_cmp++;
      if (a_ready !== 8'b0000_0100) begin n_bad++; $display("FAIL switch_rr_ready: got %b want 00000100", a_ready); end
      tick();
      n_cmp++;
      if (out_ch !== 3'd2 || out !== 8'd18 || out_neg !== 8'hED) begin
         n_bad++; $display("FAIL switch_rr_out: got ch=%0d out=%0d neg=%h want ch=2 out=18 neg=ed", out_ch, out, out_neg);
      end
      a_valid = 8'h00;
   endtask

   initial begin
      test_reset();
      test_fixed();
      test_rr_fair();
      test_rr_sparse();
      test_backpressure();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
